mem_sync_be: RTL and testbench

- Parametrised single-port synchronous RAM; successor to the fixed 16x1K distributed memory.
- Adds a valid/ready request handshake, per-byte write enables and a registered read with a ReadValid strobe.
- Zeroes the whole array after every reset.
- Sits between the CPU datapath/load-store unit and instruction/data storage.

---
 rtl/mem_sync_pkg.sv | 22 ++
 rtl/mem_byte_array.sv | 84 ++++++++
 rtl/mem_sync_be.sv | 101 ++++++++++
 tb/tb_mem_sync_be.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sync_pkg.sv
// Shared types and helpers for the byte-enable synchronous RAM.
// No logic, so there is no latency and no backpressure.
// MEM_PARITY_EN: even_par() is used by the array only when the macro is defined.
package mem_sync_pkg;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_e;

    localparam int PAR_MAX_W = 64;

    function automatic int nbytes(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    // Returns 1 when the byte holds an odd number of ones.
    function automatic logic even_par(input logic [PAR_MAX_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Word array with per-byte write enables and a registered read port.
// Latency: read data is valid 1 clock after rd_en_i; writes land on the same edge.
// Backpressure: none, it accepts any access each cycle. MEM_PARITY_EN adds per-byte parity.
module mem_byte_array
    import mem_sync_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int BYTE_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [DATA_W/BYTE_W-1:0] be_i,
    input  logic [DATA_W-1:0]        wdat_i,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        rdat_o
`ifdef MEM_PARITY_EN
    ,
    output logic                     perr_o
`endif
);

    localparam int              NB      = nbytes(DATA_W, BYTE_W);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdat_q;
    logic              in_range;

    // Addresses past DEPTH exist only when DEPTH < 2**ADDR_W; they never touch storage.
    assign in_range = {1'b0, addr_i} < DEPTH_L;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (be_i[i] && in_range) begin
                mem_q[addr_i][i*BYTE_W +: BYTE_W] <= wdat_i[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdat_q <= '0;
        end else if (rd_en_i) begin
            rdat_q <= in_range ? mem_q[addr_i] : '0;
        end
    end

    assign rdat_o = rdat_q;

`ifdef MEM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] par_chk;
    logic          perr_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (be_i[i] && in_range) begin
                par_q[addr_i][i] <= even_par(PAR_MAX_W'(wdat_i[i*BYTE_W +: BYTE_W]));
            end
        end
    end

    always_comb begin
        par_chk = '0;
        for (int i = 0; i < NB; i++) begin
            par_chk[i] = par_q[addr_i][i] ^ even_par(PAR_MAX_W'(mem_q[addr_i][i*BYTE_W +: BYTE_W]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else if (rd_en_i) begin
            perr_q <= in_range && (|par_chk);
        end
    end

    assign perr_o = perr_q;
`endif

endmodule

// File: rtl/mem_sync_be.sv
// Single-port RAM with valid/ready requests, byte enables and a post-reset zeroing sweep.
// Latency: reads return 1 clock after accept with a ReadValid pulse; writes take effect at accept.
// Backpressure: ReqReady is low for DEPTH cycles after reset. MEM_PARITY_EN adds ParityErr.
module mem_sync_be
    import mem_sync_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int BYTE_W = 8
) (
    input  logic                     CLK,
    input  logic                     Reset_n,
    input  logic                     ReqValid,
    output logic                     ReqReady,
    input  logic                     Write,
    input  logic [ADDR_W-1:0]        Address,
    input  logic [DATA_W-1:0]        DataIn,
    input  logic [DATA_W/BYTE_W-1:0] ByteEn,
    output logic [DATA_W-1:0]        DataOut,
    output logic                     ReadValid,
    output logic                     InitDone
`ifdef MEM_PARITY_EN
    ,
    output logic                     ParityErr
`endif
);

    localparam int                NB        = nbytes(DATA_W, BYTE_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rd_vld_q, rd_vld_d;
    logic              accept;
    logic [ADDR_W-1:0] arr_addr;
    logic [NB-1:0]     arr_be;
    logic [DATA_W-1:0] arr_wdat;

    assign ReqReady = (state_q == IDLE);
    assign InitDone = (state_q == IDLE);
    assign accept   = ReqValid && ReqReady;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= INIT;
            cnt_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    // During INIT the array port is owned by the sweep; requests are not visible.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_vld_d = accept && !Write;
        arr_addr = Address;
        arr_wdat = DataIn;
        arr_be   = (accept && Write) ? ByteEn : '0;
        if (state_q == INIT) begin
            cnt_d    = cnt_q + ADDR_W'(1);
            arr_addr = cnt_q;
            arr_wdat = '0;
            arr_be   = '1;
            if (cnt_q == LAST_ADDR) begin
                state_d = IDLE;
            end
        end
    end

    assign ReadValid = rd_vld_q;

`ifdef MEM_PARITY_EN
    logic arr_perr;
    assign ParityErr = rd_vld_q && arr_perr;
`endif

    mem_byte_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .BYTE_W (BYTE_W)
    ) u_arr (
        .clk     (CLK),
        .rst_n   (Reset_n),
        .addr_i  (arr_addr),
        .be_i    (arr_be),
        .wdat_i  (arr_wdat),
        .rd_en_i (rd_vld_d),
        .rdat_o  (DataOut)
`ifdef MEM_PARITY_EN
        ,
        .perr_o  (arr_perr)
`endif
    );

endmodule

// File: tb/tb_mem_sync_be.sv
// Directed bench for mem_sync_be: a word-array model checked every negedge plus literal checks.
// MEM_PARITY_EN enables the parity-corruption scenario.
module tb_mem_sync_be;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    localparam int BYTE_W = 8;
    localparam int NB     = DATA_W / BYTE_W;

    logic              CLK = 1'b0;
    logic              Reset_n;
    logic              ReqValid;
    logic              ReqReady;
    logic              Write;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] DataIn;
    logic [NB-1:0]     ByteEn;
    logic [DATA_W-1:0] DataOut;
    logic              ReadValid;
    logic              InitDone;
`ifdef MEM_PARITY_EN
    logic              ParityErr;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 CLK = ~CLK;

    mem_sync_be #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .BYTE_W (BYTE_W)
    ) dut (
        .CLK       (CLK),
        .Reset_n   (Reset_n),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .Write     (Write),
        .Address   (Address),
        .DataIn    (DataIn),
        .ByteEn    (ByteEn),
        .DataOut   (DataOut),
        .ReadValid (ReadValid),
        .InitDone  (InitDone)
`ifdef MEM_PARITY_EN
        ,
        .ParityErr (ParityErr)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: edges counted since reset release; storage is a plain word array.
    int                m_edges;
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic              m_rv;
    logic [DATA_W-1:0] m_do;

    always @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            m_edges = 0;
            m_rv    = 1'b0;
            m_do    = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else begin
            m_rv = 1'b0;
            if (m_edges >= DEPTH && ReqValid) begin
                if (Write) begin
                    for (int b = 0; b < NB; b++) begin
                        if (ByteEn[b]) m_mem[Address][b*BYTE_W +: BYTE_W] = DataIn[b*BYTE_W +: BYTE_W];
                    end
                end else begin
                    m_rv = 1'b1;
                    m_do = m_mem[Address];
                end
            end
            if (m_edges < DEPTH) m_edges++;
        end
    end

    always @(negedge CLK) begin
        chk("cyc_ready", 32'(ReqReady), 32'(m_edges >= DEPTH));
        chk("cyc_initdone", 32'(InitDone), 32'(m_edges >= DEPTH));
        chk("cyc_readvalid", 32'(ReadValid), 32'(m_rv));
        chk("cyc_dataout", 32'(DataOut), 32'(m_do));
    end

    task automatic req(input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
        ReqValid = 1'b1;
        Write    = wr;
        Address  = a;
        DataIn   = d;
        ByteEn   = be;
        @(negedge CLK);
        ReqValid = 1'b0;
    endtask

    task automatic wait_init(input string nm);
        repeat (DEPTH - 1) @(negedge CLK);
        chk({nm, "_initdone_early"}, 32'(InitDone), 32'd0);
        chk({nm, "_ready_early"}, 32'(ReqReady), 32'd0);
        @(negedge CLK);
        chk({nm, "_initdone"}, 32'(InitDone), 32'd1);
        chk({nm, "_ready"}, 32'(ReqReady), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n  = 1'b0;
        ReqValid = 1'b1;
        Write    = 1'b0;
        Address  = 10'd5;
        DataIn   = '0;
        ByteEn   = '0;
        #1;
        chk("rst_ready", 32'(ReqReady), 32'd0);
        chk("rst_initdone", 32'(InitDone), 32'd0);
        chk("rst_readvalid", 32'(ReadValid), 32'd0);
        chk("rst_dataout", 32'(DataOut), 32'd0);

        // Release with ReqValid held high: nothing is accepted until the sweep ends.
        @(negedge CLK);
        @(negedge CLK);
        Reset_n = 1'b1;
        wait_init("init");
        chk("init_no_early_read", 32'(ReadValid), 32'd0);
        @(negedge CLK);
        ReqValid = 1'b0;
        chk("init_read5_rv", 32'(ReadValid), 32'd1);
        chk("init_read5_data", 32'(DataOut), 32'h0000);
        chk("model_read5_rv", 32'(m_rv), 32'd1);
        @(negedge CLK);
        chk("init_read5_pulse", 32'(ReadValid), 32'd0);

        req(1'b1, 10'd1, 16'hBEEF, 2'b11);
        chk("wr_no_rv", 32'(ReadValid), 32'd0);
        req(1'b0, 10'd1, 16'h0000, 2'b00);
        chk("full_rd_data", 32'(DataOut), 32'hBEEF);
        chk("full_rd_rv", 32'(ReadValid), 32'd1);
        chk("model_beef", 32'(m_do), 32'hBEEF);
        @(negedge CLK);
        chk("full_rd_pulse", 32'(ReadValid), 32'd0);
        chk("full_rd_hold", 32'(DataOut), 32'hBEEF);

        req(1'b1, 10'd1, 16'h1234, 2'b01);
        req(1'b0, 10'd1, 16'h0000, 2'b00);
        chk("be01_data", 32'(DataOut), 32'hBE34);
        chk("model_be34", 32'(m_do), 32'hBE34);
        req(1'b1, 10'd1, 16'hFFFF, 2'b00);
        chk("be00_no_rv", 32'(ReadValid), 32'd0);
        req(1'b0, 10'd1, 16'h0000, 2'b00);
        chk("be00_data", 32'(DataOut), 32'hBE34);

        req(1'b1, 10'd1023, 16'hA5A5, 2'b11);
        req(1'b0, 10'd1023, 16'h0000, 2'b00);
        chk("b2b_top_data", 32'(DataOut), 32'hA5A5);
        chk("b2b_top_rv", 32'(ReadValid), 32'd1);
        req(1'b0, 10'd0, 16'h0000, 2'b00);
        chk("b2b_zero_data", 32'(DataOut), 32'h0000);
        chk("b2b_zero_rv", 32'(ReadValid), 32'd1);
        @(negedge CLK);
        chk("b2b_end_rv", 32'(ReadValid), 32'd0);

        // Reset lands between edges while a read result is being presented.
        ReqValid = 1'b1;
        Write    = 1'b0;
        Address  = 10'd1023;
        @(posedge CLK);
        #2;
        chk("mid_inflight_rv", 32'(ReadValid), 32'd1);
        chk("mid_inflight_data", 32'(DataOut), 32'hA5A5);
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_rv", 32'(ReadValid), 32'd0);
        chk("mid_rst_data", 32'(DataOut), 32'h0000);
        chk("mid_rst_ready", 32'(ReqReady), 32'd0);
        ReqValid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        Reset_n = 1'b1;

        // A second reset partway through the sweep must restart the count.
        repeat (100) @(negedge CLK);
        #2;
        Reset_n = 1'b0;
        @(negedge CLK);
        Reset_n = 1'b1;
        wait_init("reinit");

        req(1'b0, 10'd1, 16'h0000, 2'b00);
        chk("reinit_addr1", 32'(DataOut), 32'h0000);
        chk("reinit_addr1_rv", 32'(ReadValid), 32'd1);
        req(1'b0, 10'd1023, 16'h0000, 2'b00);
        chk("reinit_addr1023", 32'(DataOut), 32'h0000);

`ifdef MEM_PARITY_EN
        req(1'b1, 10'd3, 16'h00FF, 2'b11);
        dut.u_arr.par_q[3][0] = ~dut.u_arr.par_q[3][0];
        req(1'b0, 10'd3, 16'h0000, 2'b00);
        chk("par_bad_data", 32'(DataOut), 32'h00FF);
        chk("par_bad_rv", 32'(ReadValid), 32'd1);
        chk("par_bad_err", 32'(ParityErr), 32'd1);
        req(1'b0, 10'd1, 16'h0000, 2'b00);
        chk("par_clean_err", 32'(ParityErr), 32'd0);
        @(negedge CLK);
        chk("par_idle_err", 32'(ParityErr), 32'd0);
`endif

        @(negedge CLK);
        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
